// File: rtl/draw_unit.sv
// draw_unit: streams a captured 1-bpp image to a display one pixel at a
// time over a valid/ready handshake, then (optionally) writes the label.
//
// Parameters:
//   W   - image width in bits (one bit per pixel)
//   ROW - pixels per display row; W must be a multiple of ROW
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   draw                - request; sampled only in IDLE
//   label_in, image_in  - data captured when a request is accepted
//   drawn               - one-cycle pulse when a request is complete
//   busy                - high in every state except IDLE
//   pix_valid/pix_ready - pixel handshake; pix_x, pix_y, pix_on payload
//   lbl_valid/lbl_ready - label handshake; lbl_data payload
//
// Build option: define DRAW_LABEL_EN to enable the LABEL write phase.
// Without it the label outputs are tied to 0 and the last pixel goes
// straight to DONE.

module draw_unit #(
    parameter int W   = 32,
    parameter int ROW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     draw,
    input  logic [7:0]               label_in,
    input  logic [W-1:0]             image_in,
    output logic                     drawn,
    output logic                     busy,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [$clog2(ROW)-1:0]   pix_x,
    output logic [((W/ROW > 1) ? $clog2(W/ROW) : 1)-1:0] pix_y,
    output logic                     pix_on,
    output logic                     lbl_valid,
    input  logic                     lbl_ready,
    output logic [7:0]               lbl_data
);

    localparam int XW = $clog2(ROW);
    localparam int YW = (W / ROW > 1) ? $clog2(W / ROW) : 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PIXELS,
        LABEL,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   img_q, img_d;
    logic [7:0]     lbl_q, lbl_d;
    logic [IW-1:0]  idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            img_q   <= '0;
            lbl_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            lbl_q   <= lbl_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        lbl_d   = lbl_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (draw) begin
                    img_d   = image_in;
                    lbl_d   = label_in;
                    idx_d   = '0;
                    state_d = PIXELS;
                end
            end
            PIXELS: begin
                if (pix_ready) begin
                    // idx stays at the last pixel; it is reloaded on the
                    // next accepted request.
                    if (idx_q == LAST) begin
`ifdef DRAW_LABEL_EN
                        state_d = LABEL;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            LABEL: begin
`ifdef DRAW_LABEL_EN
                if (lbl_ready) begin
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign drawn     = (state_q == DONE);
    assign pix_valid = (state_q == PIXELS);
    assign pix_on    = pix_valid & img_q[idx_q];
    assign pix_x     = XW'(32'(idx_q) % ROW);
    assign pix_y     = YW'(32'(idx_q) / ROW);

`ifdef DRAW_LABEL_EN
    assign lbl_valid = (state_q == LABEL);
    assign lbl_data  = lbl_q;
`else
    logic unused_lbl;
    assign unused_lbl = ^{lbl_ready, lbl_q};
    assign lbl_valid  = 1'b0;
    assign lbl_data   = 8'd0;
`endif

endmodule

// File: tb/tb_draw_unit.sv
// tb_draw_unit: directed + randomized bench for draw_unit.
// Expected pixel stream is built from the image bits as a queue.

module tb_draw_unit;

    localparam int W   = 32;
    localparam int ROW = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         draw = 1'b0;
    logic [7:0]   label_in = 8'd0;
    logic [W-1:0] image_in = '0;
    logic         pix_ready = 1'b0;
    logic         lbl_ready = 1'b0;
    logic         drawn, busy, pix_valid, pix_on, lbl_valid;
    logic [2:0]   pix_x;
    logic [1:0]   pix_y;
    logic [7:0]   lbl_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   x;
        int   y;
        logic on;
    } pix_t;

    draw_unit #(.W(W), .ROW(ROW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .draw      (draw),
        .label_in  (label_in),
        .image_in  (image_in),
        .drawn     (drawn),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_on    (pix_on),
        .lbl_valid (lbl_valid),
        .lbl_ready (lbl_ready),
        .lbl_data  (lbl_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_drawn"}, 32'(drawn), 0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
        chk({tag, "_lbl_valid"}, 32'(lbl_valid), 0);
        chk({tag, "_pix_x"}, 32'(pix_x), 0);
        chk({tag, "_pix_y"}, 32'(pix_y), 0);
        chk({tag, "_pix_on"}, 32'(pix_on), 0);
        chk({tag, "_lbl_data"}, 32'(lbl_data), 0);
    endtask

    // mode: 0 = ready always 1, 1 = every pixel stalls once, 2 = random
    // abort_at: reset after this many pixels (-1 = never)
    task automatic do_draw(input logic [W-1:0] img, input logic [7:0] lbl,
                           input int mode, input int lbl_stall,
                           input bit hold, input bit poke, input int abort_at);
        pix_t q[$];
        int   k = 0;
        int   cyc = 0;
        int   vcyc = 0;
        bit   phase = 1'b0;
        logic r;
        for (int i = 0; i < W; i++) begin
            pix_t p;
            p.x  = i % ROW;
            p.y  = i / ROW;
            p.on = img[i];
            q.push_back(p);
        end
        image_in  = img;
        label_in  = lbl;
        draw      = 1'b1;
        pix_ready = 1'b0;
        tick;
        if (!hold) draw = 1'b0;
        chk("first_pix_latency", 32'(pix_valid), 1);
        while (q.size() > 0 && cyc < 1000) begin
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero_outputs("abort");
                draw = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                tick;
                return;
            end
            chk("pix_valid", 32'(pix_valid), 1);
            chk("pix_busy", 32'(busy), 1);
            chk("pix_lbl_valid", 32'(lbl_valid), 0);
            chk("pix_drawn", 32'(drawn), 0);
            chk("pix_x", 32'(pix_x), q[0].x);
            chk("pix_y", 32'(pix_y), q[0].y);
            chk("pix_on", 32'(pix_on), 32'(q[0].on));
            vcyc++;
            case (mode)
                0:       r = 1'b1;
                1: begin r = phase; phase = ~phase; end
                default: r = 1'($urandom_range(0, 1));
            endcase
            pix_ready = r;
            lbl_ready = 1'($urandom_range(0, 1));
            if (poke) begin
                draw = (k == 5);
                if (k == 5) begin
                    image_in = '0;
                    label_in = 8'hff;
                end
            end
            tick;
            cyc++;
            if (r) begin
                void'(q.pop_front());
                k++;
            end
        end
        chk("pix_remaining", 32'(q.size()), 0);
        if (mode == 0) chk("burst_cycles", 32'(vcyc), W);
        if (mode == 1) chk("stall_cycles", 32'(vcyc), 2 * W);
        if (poke) draw = 1'b0;
`ifdef DRAW_LABEL_EN
        for (int s = 0; s <= lbl_stall; s++) begin
            chk("lbl_valid", 32'(lbl_valid), 1);
            chk("lbl_data", 32'(lbl_data), 32'(lbl));
            chk("lbl_pix_valid", 32'(pix_valid), 0);
            chk("lbl_drawn", 32'(drawn), 0);
            lbl_ready = (s == lbl_stall);
            pix_ready = 1'($urandom_range(0, 1));
            tick;
        end
`else
        chk("nolbl_valid", 32'(lbl_valid), 0);
        chk("nolbl_data", 32'(lbl_data), 0);
`endif
        chk("done_drawn", 32'(drawn), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_pix_valid", 32'(pix_valid), 0);
        chk("done_lbl_valid", 32'(lbl_valid), 0);
        pix_ready = 1'($urandom_range(0, 1));
        lbl_ready = 1'($urandom_range(0, 1));
        tick;
        chk("drawn_once", 32'(drawn), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pix_valid", 32'(pix_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick;
        tick;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post_reset_busy", 32'(busy), 0);
        tick;
        chk("idle_hold_busy", 32'(busy), 0);

        do_draw(32'hdeadbeef, 8'd4, 0, 0, 1'b0, 1'b0, -1);
        do_draw(32'hdeadbeef, 8'h5a, 1, 0, 1'b0, 1'b0, -1);
        do_draw(32'hdeadbeef, 8'h11, 0, 0, 1'b0, 1'b1, -1);
        do_draw(W'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 10);
        chk("after_abort_busy", 32'(busy), 0);
        do_draw(W'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, -1);
        do_draw(W'($urandom), 8'($urandom), 0, 5, 1'b0, 1'b0, -1);
        do_draw(W'($urandom), 8'($urandom), 2, 1, 1'b1, 1'b0, -1);
        do_draw(W'($urandom), 8'($urandom), 2, 0, 1'b1, 1'b0, -1);
        draw = 1'b0;
        for (int n = 0; n < 4; n++) begin
            do_draw(W'($urandom), 8'($urandom), 2,
                    int'($urandom_range(0, 4)), 1'b0, 1'b0, -1);
        end
        tick;
        chk("final_idle", 32'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
